dmi_jtag_dtm: RTL and testbench

//  RISC-V debug transport module (DTM), JTAG side. Consumes the TAP control

---
 rtl/dmi_pkg.sv | 44 ++++
 rtl/dmi_jtag_dr.sv | 40 ++++
 rtl/dmi_jtag_dtm.sv | 172 +++++++++++++++++
 tb/tb_dmi_jtag_dtm.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_pkg.sv
// ============================================================================
//  Module      : dmi_pkg
//  Description : Shared types and dtmcs field positions for the JTAG DTM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmi_pkg;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DTM_OK     = 2'd0,
        DTM_FAILED = 2'd2,
        DTM_BUSY   = 2'd3
    } dtm_err_e;

    localparam logic [3:0] DTM_VERSION = 4'd1;

    localparam int DTMCS_HARDRESET = 17;
    localparam int DTMCS_DMIRESET  = 16;
    localparam int DTMCS_IDLE_LSB  = 12;
    localparam int DTMCS_STAT_LSB  = 10;
    localparam int DTMCS_ABITS_LSB = 4;

    // Address is left out of the request struct because its width is a
    // per-instance parameter.
    typedef struct packed {
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

`default_nettype wire

// File: rtl/dmi_jtag_dr.sv
// ============================================================================
//  Module      : dmi_jtag_dr
//  Description : Generic JTAG data register with parallel capture and a
//                right-shifting serial path (TDI enters at the MSB).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmi_jtag_dr #(
    parameter int WIDTH = 32
) (
    input  logic             tck_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic             tdi_i,
    input  logic [WIDTH-1:0] capture_data_i,
    output logic [WIDTH-1:0] dr_o,
    output logic             tdo_o
);

    logic [WIDTH-1:0] r_dr;

    always_ff @(posedge tck_i) begin
        if (!rst_ni || clear_i) begin
            r_dr <= '0;
        end else if (capture_i) begin
            r_dr <= capture_data_i;
        end else if (shift_i) begin
            r_dr <= {tdi_i, r_dr[WIDTH-1:1]};
        end
    end

    assign dr_o  = r_dr;
    assign tdo_o = r_dr[0];

endmodule

`default_nettype wire

// File: rtl/dmi_jtag_dtm.sv
// ============================================================================
//  Module      : dmi_jtag_dtm
//  Description : RISC-V JTAG debug transport module: dtmcs/dmi registers and
//                the valid/ready bridge toward the debug module.
//                Optional DMI_HARDRESET_EN enables dtmcs.dmihardreset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmi_jtag_dtm
    import dmi_pkg::*;
#(
    parameter int ABITS       = 7,
    parameter int IDLE_CYCLES = 1
) (
    input  logic             tck_i,
    input  logic             rst_ni,
    input  logic             dmi_clear_i,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic             update_i,
    input  logic             tdi_i,
    input  logic             dtmcs_select_i,
    output logic             dtmcs_tdo_o,
    input  logic             dmi_select_i,
    output logic             dmi_tdo_o,
    output logic             dmi_req_valid_o,
    input  logic             dmi_req_ready_i,
    output logic [ABITS-1:0] dmi_req_addr_o,
    output logic [1:0]       dmi_req_op_o,
    output logic [31:0]      dmi_req_data_o,
    input  logic             dmi_resp_valid_i,
    output logic             dmi_resp_ready_o,
    input  logic [31:0]      dmi_resp_data_i,
    input  logic [1:0]       dmi_resp_resp_i,
    output logic             dmi_rst_no
);

    localparam int         c_DMI_W = ABITS + 34;
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_REQ   = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_error;
    logic [ABITS-1:0] r_addr;
    dmi_req_t         r_req;
    logic             r_req_valid;
    logic             r_resp_ready;

    logic [31:0]      w_dtmcs_dr;
    logic [31:0]      w_dtmcs_cap;
    logic [c_DMI_W-1:0] w_dmi_dr;
    logic [c_DMI_W-1:0] w_dmi_cap;
    logic [1:0]       w_cap_err;
    logic [1:0]       w_dmi_op;
    dmi_resp_t        w_resp;
    logic             w_unused_dtmcs;

    assign w_resp      = '{data: dmi_resp_data_i, resp: dmi_resp_resp_i};
    assign w_dtmcs_cap = {17'd0, 3'(IDLE_CYCLES), r_error, 6'(ABITS), DTM_VERSION};
    // A dmi capture while a transaction is outstanding already reports busy.
    assign w_cap_err   = (r_state != c_IDLE) ? DTM_BUSY : r_error;
    assign w_dmi_cap   = {r_addr, r_req.data, w_cap_err};
    assign w_dmi_op    = w_dmi_dr[1:0];
    assign w_unused_dtmcs = ^w_dtmcs_dr;

    dmi_jtag_dr #(.WIDTH(32)) u_dtmcs_dr (
        .tck_i          (tck_i),
        .rst_ni         (rst_ni),
        .clear_i        (dmi_clear_i),
        .capture_i      (capture_i & dtmcs_select_i & ~update_i),
        .shift_i        (shift_i & dtmcs_select_i & ~update_i),
        .tdi_i          (tdi_i),
        .capture_data_i (w_dtmcs_cap),
        .dr_o           (w_dtmcs_dr),
        .tdo_o          (dtmcs_tdo_o)
    );

    dmi_jtag_dr #(.WIDTH(c_DMI_W)) u_dmi_dr (
        .tck_i          (tck_i),
        .rst_ni         (rst_ni),
        .clear_i        (dmi_clear_i),
        .capture_i      (capture_i & dmi_select_i & ~update_i),
        .shift_i        (shift_i & dmi_select_i & ~update_i),
        .tdi_i          (tdi_i),
        .capture_data_i (w_dmi_cap),
        .dr_o           (w_dmi_dr),
        .tdo_o          (dmi_tdo_o)
    );

`ifdef DMI_HARDRESET_EN
    logic r_dmi_rst_n;
    assign dmi_rst_no = r_dmi_rst_n;
`else
    assign dmi_rst_no = 1'b1;
`endif

    always_ff @(posedge tck_i) begin
        if (!rst_ni || dmi_clear_i) begin
            r_state      <= c_IDLE;
            r_error      <= DTM_OK;
            r_addr       <= '0;
            r_req        <= '{op: DTM_NOP, data: 32'd0};
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b0;
`ifdef DMI_HARDRESET_EN
            r_dmi_rst_n  <= 1'b1;
`endif
        end else begin
`ifdef DMI_HARDRESET_EN
            r_dmi_rst_n <= 1'b1;
`endif
            case (r_state)
                c_REQ: begin
                    if (dmi_req_ready_i) begin
                        r_req_valid  <= 1'b0;
                        r_resp_ready <= 1'b1;
                        r_state      <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (dmi_resp_valid_i) begin
                        r_resp_ready <= 1'b0;
                        r_state      <= c_IDLE;
                        if (r_req.op == DTM_READ) r_req.data <= w_resp.data;
                        if (w_resp.resp != 2'd0)  r_error    <= DTM_FAILED;
                    end
                end
                default: ;
            endcase

            // JTAG-side events are placed last so they win over bus events.
            if (update_i) begin
                if (dtmcs_select_i) begin
                    if (w_dtmcs_dr[DTMCS_DMIRESET]) r_error <= DTM_OK;
`ifdef DMI_HARDRESET_EN
                    if (w_dtmcs_dr[DTMCS_HARDRESET]) begin
                        r_state      <= c_IDLE;
                        r_req_valid  <= 1'b0;
                        r_resp_ready <= 1'b0;
                        r_error      <= DTM_OK;
                        r_dmi_rst_n  <= 1'b0;
                    end
`endif
                end
                if (dmi_select_i && r_error == DTM_OK) begin
                    if (r_state != c_IDLE) begin
                        r_error <= DTM_BUSY;
                    end else if (w_dmi_op == DTM_READ || w_dmi_op == DTM_WRITE) begin
                        r_addr      <= w_dmi_dr[c_DMI_W-1:34];
                        r_req.data  <= w_dmi_dr[33:2];
                        r_req.op    <= dtm_op_e'(w_dmi_op);
                        r_req_valid <= 1'b1;
                        r_state     <= c_REQ;
                    end
                end
            end else if (capture_i && dmi_select_i && r_state != c_IDLE) begin
                r_error <= DTM_BUSY;
            end
        end
    end

    assign dmi_req_valid_o  = r_req_valid;
    assign dmi_resp_ready_o = r_resp_ready;
    assign dmi_req_addr_o   = r_addr;
    assign dmi_req_op_o     = r_req.op;
    assign dmi_req_data_o   = r_req.data;

endmodule

`default_nettype wire

// File: tb/tb_dmi_jtag_dtm.sv
// ============================================================================
//  Module      : tb_dmi_jtag_dtm
//  Description : Self-checking bench for dmi_jtag_dtm with a debug-module
//                responder and a request scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmi_jtag_dtm;

    localparam int ABITS = 7;
    localparam int DW    = ABITS + 34;

    logic        tck = 1'b0;
    logic        rst_ni = 1'b0;
    logic        dmi_clear_i = 1'b0;
    logic        capture_i = 1'b0;
    logic        shift_i = 1'b0;
    logic        update_i = 1'b0;
    logic        tdi_i = 1'b0;
    logic        dtmcs_select_i = 1'b0;
    logic        dtmcs_tdo_o;
    logic        dmi_select_i = 1'b0;
    logic        dmi_tdo_o;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i;
    logic [ABITS-1:0] dmi_req_addr_o;
    logic [1:0]  dmi_req_op_o;
    logic [31:0] dmi_req_data_o;
    logic        dmi_resp_valid_i;
    logic        dmi_resp_ready_o;
    logic [31:0] dmi_resp_data_i;
    logic [1:0]  dmi_resp_resp_i;
    logic        dmi_rst_no;

    always #5 tck = ~tck;

    dmi_jtag_dtm #(.ABITS(ABITS), .IDLE_CYCLES(1)) dut (
        .tck_i            (tck),
        .rst_ni           (rst_ni),
        .dmi_clear_i      (dmi_clear_i),
        .capture_i        (capture_i),
        .shift_i          (shift_i),
        .update_i         (update_i),
        .tdi_i            (tdi_i),
        .dtmcs_select_i   (dtmcs_select_i),
        .dtmcs_tdo_o      (dtmcs_tdo_o),
        .dmi_select_i     (dmi_select_i),
        .dmi_tdo_o        (dmi_tdo_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_addr_o   (dmi_req_addr_o),
        .dmi_req_op_o     (dmi_req_op_o),
        .dmi_req_data_o   (dmi_req_data_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_data_i  (dmi_resp_data_i),
        .dmi_resp_resp_i  (dmi_resp_resp_i),
        .dmi_rst_no       (dmi_rst_no)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [40:0] exp_req_q[$];
    int          req_beats = 0;
    int          rst_low_total = 0;

    int          dm_ready_delay = 2;
    bit          dm_withhold = 1'b0;
    bit          dm_flush = 1'b0;
    logic [31:0] dm_resp_data = 32'd0;
    logic [1:0]  dm_resp_code = 2'd0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [40:0] req_word(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
        return {a, op, d};
    endfunction

    function automatic logic [40:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {a, d, op};
    endfunction

    function automatic logic [40:0] dtmcs_exp(input logic [1:0] stat);
        logic [40:0] v;
        v = 41'h1071 | (41'(stat) << 10);
        return v;
    endfunction

    // Debug-module responder: accepts each request after dm_ready_delay
    // cycles and answers once resp_ready is seen, unless withheld.
    initial begin
        int          wait_cnt;
        bit          pending;
        logic [40:0] exp;
        wait_cnt = 0;
        pending  = 1'b0;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_data_i  = 32'd0;
        dmi_resp_resp_i  = 2'd0;
        forever begin
            @(negedge tck);
            dmi_req_ready_i  = 1'b0;
            dmi_resp_valid_i = 1'b0;
            if (!rst_ni || dm_flush) begin
                pending  = 1'b0;
                wait_cnt = 0;
            end else if (dmi_req_valid_o && !pending) begin
                if (wait_cnt >= dm_ready_delay) begin
                    dmi_req_ready_i = 1'b1;
                    wait_cnt = 0;
                    pending  = 1'b1;
                    req_beats++;
                    if (exp_req_q.size() == 0) begin
                        check_value("req_unexpected", 64'd1, 64'd0);
                    end else begin
                        exp = exp_req_q.pop_front();
                        check_value("req_beat", {dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o}, exp);
                    end
                end else begin
                    wait_cnt++;
                end
            end else if (pending && !dm_withhold && dmi_resp_ready_o) begin
                dmi_resp_valid_i = 1'b1;
                dmi_resp_data_i  = dm_resp_data;
                dmi_resp_resp_i  = dm_resp_code;
                pending = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge tck);
            if (!dmi_rst_no) rst_low_total++;
        end
    end

    task automatic scan(input bit is_dmi, input logic [40:0] din, output logic [40:0] dout);
        int len;
        len  = is_dmi ? DW : 32;
        dout = '0;
        @(negedge tck);
        dtmcs_select_i = !is_dmi;
        dmi_select_i   = is_dmi;
        capture_i      = 1'b1;
        @(negedge tck);
        capture_i = 1'b0;
        shift_i   = 1'b1;
        for (int i = 0; i < len; i++) begin
            tdi_i   = din[i];
            dout[i] = is_dmi ? dmi_tdo_o : dtmcs_tdo_o;
            @(negedge tck);
        end
        shift_i  = 1'b0;
        update_i = 1'b1;
        @(negedge tck);
        update_i       = 1'b0;
        dmi_select_i   = 1'b0;
        dtmcs_select_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((dmi_req_valid_o || dmi_resp_ready_o) && n < 200) begin
            @(negedge tck);
            n++;
        end
        check_value(tag, 64'(n < 200), 64'd1);
    endtask

    task automatic wait_resp_ready(input string tag);
        int n;
        n = 0;
        while (!dmi_resp_ready_o && n < 200) begin
            @(negedge tck);
            n++;
        end
        check_value(tag, 64'(n < 200), 64'd1);
    endtask

    initial begin
        logic [40:0] dout;
        int          beats0;
        int          rst0;

        repeat (3) @(negedge tck);
        check_value("rst_req_valid", dmi_req_valid_o, 1'b0);
        check_value("rst_resp_ready", dmi_resp_ready_o, 1'b0);
        check_value("rst_dmi_rst_no", dmi_rst_no, 1'b1);
        check_value("rst_tdo", {dtmcs_tdo_o, dmi_tdo_o}, 2'b00);
        rst_ni = 1'b1;

        // dtmcs identification
        scan(1'b0, 41'd0, dout);
        check_value("dtmcs_idle", dout[31:0], 32'h00001071);

        // write transaction
        beats0 = req_beats;
        exp_req_q.push_back(req_word(7'h10, 2'd2, 32'hDEADBEEF));
        scan(1'b1, dmi_word(7'h10, 32'hDEADBEEF, 2'd2), dout);
        check_value("wr_req_valid", dmi_req_valid_o, 1'b1);
        wait_idle("wr_idle_timeout");
        check_value("wr_beats", req_beats - beats0, 1);
        scan(1'b1, 41'd0, dout);
        check_value("wr_capture", dout, dmi_word(7'h10, 32'hDEADBEEF, 2'd0));

        // read transaction
        dm_resp_data = 32'h12345678;
        exp_req_q.push_back(req_word(7'h11, 2'd1, 32'd0));
        scan(1'b1, dmi_word(7'h11, 32'd0, 2'd1), dout);
        wait_idle("rd_idle_timeout");
        scan(1'b1, 41'd0, dout);
        check_value("rd_capture", dout, dmi_word(7'h11, 32'h12345678, 2'd0));

        // busy: capture while response withheld
        beats0 = req_beats;
        dm_withhold = 1'b1;
        exp_req_q.push_back(req_word(7'h12, 2'd2, 32'hA5A5A5A5));
        scan(1'b1, dmi_word(7'h12, 32'hA5A5A5A5, 2'd2), dout);
        wait_resp_ready("busy_wait_timeout");
        scan(1'b1, dmi_word(7'h13, 32'h11111111, 2'd2), dout);
        check_value("busy_capture", dout, dmi_word(7'h12, 32'hA5A5A5A5, 2'd3));
        scan(1'b0, 41'h1_0000, dout);
        check_value("busy_dmistat", dout[31:0], dtmcs_exp(2'd3));
        scan(1'b0, 41'd0, dout);
        check_value("busy_cleared", dout[31:0], dtmcs_exp(2'd0));
        check_value("busy_still_wait", dmi_resp_ready_o, 1'b1);
        dm_withhold = 1'b0;
        wait_idle("busy_idle_timeout");
        exp_req_q.push_back(req_word(7'h14, 2'd2, 32'h0BADF00D));
        scan(1'b1, dmi_word(7'h14, 32'h0BADF00D, 2'd2), dout);
        wait_idle("busy_next_timeout");
        check_value("busy_beats", req_beats - beats0, 2);

        // failed response is sticky
        dm_resp_code = 2'd2;
        dm_resp_data = 32'hCAFEF00D;
        exp_req_q.push_back(req_word(7'h15, 2'd1, 32'd0));
        scan(1'b1, dmi_word(7'h15, 32'd0, 2'd1), dout);
        wait_idle("fail_idle_timeout");
        dm_resp_code = 2'd0;
        scan(1'b0, 41'd0, dout);
        check_value("fail_dmistat", dout[31:0], dtmcs_exp(2'd2));
        scan(1'b1, dmi_word(7'h16, 32'd0, 2'd1), dout);
        check_value("fail_capture", dout, dmi_word(7'h15, 32'hCAFEF00D, 2'd2));
        check_value("fail_upd_ignored", dmi_req_valid_o, 1'b0);
        scan(1'b0, 41'h1_0000, dout);
        check_value("fail_sticky", dout[31:0], dtmcs_exp(2'd2));
        scan(1'b0, 41'd0, dout);
        check_value("fail_cleared", dout[31:0], dtmcs_exp(2'd0));

        // dmihardreset while waiting for a response
        dm_withhold = 1'b1;
        exp_req_q.push_back(req_word(7'h17, 2'd2, 32'h00000055));
        scan(1'b1, dmi_word(7'h17, 32'h00000055, 2'd2), dout);
        wait_resp_ready("hr_wait_timeout");
        rst0 = rst_low_total;
        scan(1'b0, 41'h2_0000, dout);
        check_value("hr_capture", dout[31:0], dtmcs_exp(2'd0));
        repeat (4) @(negedge tck);
`ifdef DMI_HARDRESET_EN
        check_value("hr_rst_pulse", rst_low_total - rst0, 1);
        check_value("hr_resp_ready", dmi_resp_ready_o, 1'b0);
        check_value("hr_req_valid", dmi_req_valid_o, 1'b0);
        dm_flush = 1'b1;
        @(negedge tck);
        dm_flush = 1'b0;
        dm_withhold = 1'b0;
`else
        check_value("hr_rst_pulse", rst_low_total - rst0, 0);
        check_value("hr_resp_ready", dmi_resp_ready_o, 1'b1);
        dm_withhold = 1'b0;
        wait_idle("hr_idle_timeout");
`endif
        scan(1'b0, 41'd0, dout);
        check_value("hr_dmistat", dout[31:0], dtmcs_exp(2'd0));
        check_value("req_queue_empty", exp_req_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
